// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit seven-segment driver: prescaled slot rotation,
// per-slot dead time and a double-buffered BCD frame. Define SEG_LZB_EN for leading-zero blanking.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_in,
  input  logic        load,
  output logic [1:0]  en,
  output logic [3:0]  in,
  output logic        frame_start,
  output logic        pending
);

  localparam int              CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD     = CNT_W'(DEAD_CYCLES);
  localparam logic [1:0]       SLOT_LAST = 2'b11;
  localparam logic [3:0]       BLANK     = 4'hF;

  logic [CNT_W-1:0] cnt;
  logic [15:0]      display;
  logic [15:0]      shadow;

  logic [CNT_W-1:0] cnt_n;
  logic [1:0]       en_n;
  logic [15:0]      display_n;
  logic [15:0]      shadow_n;
  logic             pending_n;
  logic             wrap;
  logic             boundary;
  logic [3:0]       in_n;

  // Value written into the display register whenever a frame is committed.
  function automatic logic [15:0] commit_value(input logic [15:0] frame);
`ifdef SEG_LZB_EN
    logic [15:0] r;
    logic        lead;
    r    = frame;
    lead = 1'b1;
    // Slot 3 (bits [3:0]) is never blanked so an all-zero frame still shows "0".
    for (int i = 3; i >= 1; i--) begin
      if (lead && r[4*i +: 4] == 4'h0) r[4*i +: 4] = BLANK;
      else                             lead = 1'b0;
    end
    return r;
`else
    return frame;
`endif
  endfunction

  function automatic logic [3:0] slot_nibble(input logic [15:0] frame, input logic [1:0] slot);
    case (slot)
      2'd0:    return frame[15:12];
      2'd1:    return frame[11:8];
      2'd2:    return frame[7:4];
      default: return frame[3:0];
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    wrap      = (cnt == CNT_LAST);
    boundary  = wrap && (en == SLOT_LAST);
    cnt_n     = wrap ? '0 : cnt + 1'b1;
    en_n      = wrap ? en + 2'd1 : en;
    display_n = display;
    shadow_n  = load ? digits_in : shadow;
    pending_n = pending;

    if (boundary) begin
      pending_n = 1'b0;
      // A load coinciding with the boundary bypasses the shadow entirely.
      if (load)         display_n = commit_value(digits_in);
      else if (pending) display_n = commit_value(shadow);
    end else if (load) begin
      pending_n = 1'b1;
    end

    // in is registered from next-state values so it always matches the current (cnt, en).
    in_n = (cnt_n < DEAD) ? BLANK : slot_nibble(display_n, en_n);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      en          <= 2'b00;
      display     <= 16'hFFFF;
      shadow      <= 16'hFFFF;
      in          <= BLANK;
      frame_start <= 1'b0;
      pending     <= 1'b0;
    end else begin
      cnt         <= cnt_n;
      en          <= en_n;
      display     <= display_n;
      shadow      <= shadow_n;
      in          <= in_n;
      frame_start <= boundary;
      pending     <= pending_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: two instances (dead time 2 and 0) share stimulus;
// a slot/phase model derived from the cycle count predicts every output.
module tb_seg_scan_ctrl;

  localparam int R     = 8;
  localparam int DEAD  = 2;
  localparam int FRAME = 4 * R;

  typedef struct packed {
    logic [1:0] en;
    logic [3:0] in;
    logic       fs;
    logic       pend;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits_in;
  logic        load;
  logic [1:0]  en_a, en_b;
  logic [3:0]  in_a, in_b;
  logic        fs_a, fs_b;
  logic        pd_a, pd_b;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  // Reference model state: cycles since reset release plus the frame contents.
  int         m_t;
  logic [3:0] m_disp [4];
  logic [15:0] m_shadow;
  logic       m_pend;

  seg_scan_ctrl #(.REFRESH_DIV(R), .DEAD_CYCLES(DEAD)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .load(load),
    .en(en_a), .in(in_a), .frame_start(fs_a), .pending(pd_a)
  );

  seg_scan_ctrl #(.REFRESH_DIV(R), .DEAD_CYCLES(0)) dut_nodead (
    .clk(clk), .rst(rst), .digits_in(digits_in), .load(load),
    .en(en_b), .in(in_b), .frame_start(fs_b), .pending(pd_b)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog t=%0d actual=timeout required=finish", m_t);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s t=%0d actual=%h required=%h", name, m_t, act, req);
    end
  endtask

  task automatic model_reset();
    m_t      = 0;
    m_shadow = 16'hFFFF;
    m_pend   = 1'b0;
    for (int i = 0; i < 4; i++) m_disp[i] = 4'hF;
  endtask

  task automatic model_show(input logic [15:0] d);
    for (int i = 0; i < 4; i++) m_disp[i] = d[15-4*i -: 4];
`ifdef SEG_LZB_EN
    for (int i = 0; i < 3; i++) begin
      if (m_disp[i] != 4'h0) break;
      m_disp[i] = 4'hF;
    end
`endif
  endtask

  // Advance the model by one clock edge with the given inputs and queue the expected outputs.
  task automatic step(input logic ld, input logic [15:0] d);
    exp_t e;
    int   slot, pos;
    logic bnd;
    load      = ld;
    digits_in = d;
    m_t++;
    bnd = (m_t % FRAME) == 0;
    if (bnd) begin
      if (ld) begin
        model_show(d);
        m_shadow = d;
      end else if (m_pend) begin
        model_show(m_shadow);
      end
      m_pend = 1'b0;
    end else if (ld) begin
      m_shadow = d;
      m_pend   = 1'b1;
    end
    slot = (m_t / R) % 4;
    pos  = m_t % R;
    e.a.en   = 2'(slot);
    e.a.in   = (pos < DEAD) ? 4'hF : m_disp[slot];
    e.a.fs   = bnd;
    e.a.pend = m_pend;
    e.b.en   = 2'(slot);
    e.b.in   = m_disp[slot];
    e.b.fs   = bnd;
    e.b.pend = m_pend;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000);
  endtask

  // Idle until the next step lands on a frame-boundary edge.
  task automatic align_boundary();
    while (((m_t + 1) % FRAME) != 0) step(1'b0, 16'h0000);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_a"}, {en_a, in_a, fs_a, pd_a}, {2'b00, 4'hF, 1'b0, 1'b0});
    check({tag, "_b"}, {en_b, in_b, fs_b, pd_b}, {2'b00, 4'hF, 1'b0, 1'b0});
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scan_dead2",  {en_a, in_a, fs_a, pd_a}, e.a);
      check("scan_dead0",  {en_b, in_b, fs_b, pd_b}, e.b);
    end
  end

  initial begin
    logic [15:0] d;
    rst       = 1'b1;
    load      = 1'b0;
    digits_in = 16'h0000;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Idle scan, then a mid-frame load.
    idle(64);
    idle(5);
    step(1'b1, 16'h1234);
    idle(60);

    // Two loads in one frame: the last one wins.
    step(1'b1, 16'h1111);
    idle(3);
    step(1'b1, 16'h5678);
    idle(40);

    // Load landing exactly on the boundary edge.
    align_boundary();
    step(1'b1, 16'h0945);
    idle(40);

    // Dead-time-free instance with a mix of letter codes and blank.
    step(1'b1, 16'h9ABF);
    align_boundary();
    idle(40);

    // Randomised loads, biased toward zero nibbles.
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 4; k++)
        d[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      step($urandom_range(0, 7) == 0, d);
    end
    step(1'b1, 16'h0000);
    align_boundary();
    idle(40);

    // Reset mid-slot 2 while 1234 is displayed.
    align_boundary();
    step(1'b1, 16'h1234);
    idle(19);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset("async_rst");
    repeat (2) @(negedge clk);
    check_reset("held_rst");
    rst = 1'b0;
    model_reset();
    idle(70);

    @(posedge clk);
    #2;
    check("drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Scan controller that sources the digit-select/BCD pair consumed by the 4-digit seven-segment driver (`en[1:0]`, `in[3:0]`).
- Holds a 4-digit BCD frame and time-multiplexes it across the four anodes at a programmable refresh rate.
- Inserts per-slot blanking (dead time) to suppress ghosting.
- Double-buffers new frames so the displayed time/alarm value never tears mid-scan.
- Sits between the clock/alarm counters and the segment driver.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot; legal range 2..2^20.
- DEAD_CYCLES, 16, blanked cycles at the start of each slot; legal range 0..REFRESH_DIV-1; 0 disables blanking.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- digits_in, input, 16, frame to display; [15:12] = leftmost digit (slot 0), [3:0] = rightmost (slot 3).
- load, input, 1, single-cycle strobe capturing digits_in into the shadow register.
- en, output, 2, digit slot select to driver; 00 = leftmost (anode 0111) … 11 = rightmost (anode 1110).
- in, output, 4, nibble for the current slot; 4'hF = blank.
- frame_start, output, 1, one-cycle pulse when slot 0 begins.
- pending, output, 1, shadow holds a frame not yet committed to display.

Behaviour:
- Reset (async, rst=1): prescaler cnt=0, en=00, display reg=16'hFFFF, shadow=16'hFFFF, in=4'hF, frame_start=0, pending=0.
- All outputs are registered. No combinational path from inputs to outputs.
- Prescaler:
  - cnt counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, en advances 00→01→10→11→00.
- in: 4'hF while cnt < DEAD_CYCLES; otherwise the display-reg nibble selected by en.
  - Timing: in is registered. In any cycle, in must match the rule evaluated on the current (cnt, en) values.
- Nibble pass-through:
  - Values 0–9 and A–E pass through unchanged; the driver blanks non-BCD values.
  - F is the explicit blank code.
- Frame boundary is the edge where cnt wraps while en=11. At that edge:
  - en becomes 00 and cnt becomes 0.
  - frame_start=1 for exactly that cycle.
  - If pending=1: display ← shadow and pending ← 0.
- load=1 (not at a boundary): shadow ← digits_in and pending ← 1.
  - Multiple loads before a boundary: the last one wins.
- load=1 on the frame-boundary edge: display ← digits_in directly; pending stays 0; shadow ← digits_in.
- The display reg never changes except at a frame boundary or on reset.
- Reset asserted mid-slot: everything returns to reset values immediately. After deassertion, the first slot 0 begins with cnt=0. frame_start does not pulse on reset exit.
- Steady-state period:
  - One full scan = 4·REFRESH_DIV cycles.
  - frame_start period = 4·REFRESH_DIV.

Optional Feature:
Macro SEG_LZB_EN (leading-zero blanking).
- Defined: at commit time, leading 0 nibbles of the committed frame (scanning from slot 0) are replaced with F in the display reg. The rightmost digit (slot 3) is never blanked.
  - 0 0 4 5 → F F 4 5.
  - 0 0 0 0 → F F F 0.
- Not defined: the frame is displayed verbatim (0 0 4 5 shows as 0 0 4 5).
- No port or parameter change either way.

Test Plan:
All scenarios use REFRESH_DIV=8 and DEAD_CYCLES=2 unless noted.
1. Reset then idle 64 cycles → en sequence 00,01,10,11 each held 8 cycles; in=F throughout; frame_start high at cycles 32 and 64 only; pending=0.
2. load with digits_in=16'h1234 at cycle 5 → pending=1 until the next boundary (cycle 32), then 0. In the following frame, in = F,F,1×6 in slot 0, F,F,2×6 in slot 1, F,F,3×6 in slot 2, F,F,4×6 in slot 3.
3. Loads of 16'h1111 then 16'h5678 within the same frame → only 5678 is displayed next frame; 1111 never appears on in.
4. load 16'h0945 exactly on the boundary edge → 0945 (or F945 with SEG_LZB_EN) shown in the immediately starting frame; pending never rises.
5. rst pulsed mid-slot 2 with display=1234 → en=00, in=F, pending=0 asynchronously; after release, a full frame of F; no frame_start until 4·8 cycles later.
6. DEAD_CYCLES=0 with display 16'h9ABF → slots show 9, A, B, F for all 8 cycles each, with no blank gap.
